// File: rtl/cmd_proto_pkg.sv
// Protocol constants, parser state encoding and reply packet types shared
// by the command responder and its reply buffer.
package cmd_proto_pkg;

  localparam logic [7:0] OP_READ  = 8'h01;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_PING  = 8'h03;

  localparam logic [7:0] RPL_PING = 8'hA5;
  localparam logic [7:0] RPL_ERR  = 8'hEE;

  localparam int REPLY_MAX   = 6;
  localparam int REPLY_LEN_W = $clog2(REPLY_MAX + 1);

  // Byte 0 of a packet is element [0], i.e. the first byte sent.
  typedef logic [REPLY_MAX-1:0][7:0] reply_pkt_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA0,
    ST_DATA1,
    ST_DATA2,
    ST_DATA3,
    ST_EXEC,
    ST_RDWAIT,
    ST_REPLY
  } parser_state_t;

  // States in which the parser is still collecting bytes of a command.
  function automatic logic is_cmd_state(parser_state_t s);
    return (s == ST_ADDR) || (s == ST_DATA0) || (s == ST_DATA1) ||
           (s == ST_DATA2) || (s == ST_DATA3);
  endfunction

endpackage

// File: rtl/cmd_responder_if.sv
// Byte-stream, reply and register-bus signals of the command responder.
// The host side (FX2 logic / register block) uses master, the responder uses slave.
interface cmd_responder_if #(
  parameter int ADDR_W = 8
);

  logic              cmd_wr;
  logic [7:0]        cmd;
  logic [7:0]        reply;
  logic              reply_rdy;
  logic              reply_ack;
  logic              reply_end;
  logic [ADDR_W-1:0] reg_addr;
  logic [31:0]       reg_wdata;
  logic              reg_wr;
  logic              reg_rd;
  logic [31:0]       reg_rdata;
  logic [7:0]        cmd_dropped;

  modport master (
    output cmd_wr,
    output cmd,
    output reply_ack,
    output reg_rdata,
    input  reply,
    input  reply_rdy,
    input  reply_end,
    input  reg_addr,
    input  reg_wdata,
    input  reg_wr,
    input  reg_rd,
    input  cmd_dropped
  );

  modport slave (
    input  cmd_wr,
    input  cmd,
    input  reply_ack,
    input  reg_rdata,
    output reply,
    output reply_rdy,
    output reply_end,
    output reg_addr,
    output reg_wdata,
    output reg_wr,
    output reg_rd,
    output cmd_dropped
  );

endinterface

// File: rtl/cmd_responder_reply_buf.sv
// Load-and-shift reply buffer: holds up to REPLY_MAX bytes, presents byte 0
// and shifts one byte per acknowledge until the length count reaches zero.
module reply_buf
  import cmd_proto_pkg::*;
(
  input  logic                   fx2_clk,
  input  logic                   reset,
  input  logic                   load,
  input  reply_pkt_t             load_data,
  input  logic [REPLY_LEN_W-1:0] load_len,
  input  logic                   ack,
  output logic [7:0]             reply,
  output logic                   reply_rdy,
  output logic                   reply_end
);

  reply_pkt_t             data_q;
  logic [REPLY_LEN_W-1:0] len_q;

  always_ff @(posedge fx2_clk) begin
    if (reset) begin
      data_q <= '0;
      len_q  <= '0;
    end else if (load) begin
      data_q <= load_data;
      len_q  <= load_len;
    end else if (ack && (len_q != '0)) begin
      // Acks with an empty buffer fall through here and are ignored.
      data_q <= {8'h00, data_q[REPLY_MAX-1:1]};
      len_q  <= len_q - REPLY_LEN_W'(1);
    end
  end

  assign reply     = data_q[0];
  assign reply_rdy = (len_q != '0);
  assign reply_end = (len_q == REPLY_LEN_W'(1));

endmodule

// File: rtl/cmd_responder.sv
// FX2 command parser: decodes READ/WRITE/PING byte streams, drives the register
// bus and queues a reply packet. Build option REPLY_TIMEOUT_EN abandons stalled commands.
//
// state      | meaning
// ST_IDLE    | waiting for an opcode byte
// ST_ADDR    | waiting for the address byte
// ST_DATA0-3 | collecting write data, least significant byte first
// ST_EXEC    | one-cycle reg_wr or reg_rd strobe
// ST_RDWAIT  | reg_rdata valid, captured straight into the reply
// ST_REPLY   | reply bytes presented until the last one is acked
module cmd_responder
  import cmd_proto_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int ADDR_W         = 8
) (
  input logic            fx2_clk,
  input logic            reset,
  cmd_responder_if.slave bus
);

  parser_state_t          state_q;
  parser_state_t          state_d;
  logic                   is_write_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [31:0]            wdata_q;
  logic [7:0]             drop_q;
  logic                   wr_pulse;
  logic                   rd_pulse;
  logic                   buf_load;
  reply_pkt_t             buf_data;
  logic [REPLY_LEN_W-1:0] buf_len;
  logic                   reply_end_w;
  logic                   accept;

  // Bytes are only taken in IDLE and the command-collecting states.
  assign accept = bus.cmd_wr && ((state_q == ST_IDLE) || is_cmd_state(state_q));

`ifdef REPLY_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TMO_W-1:0] tmo_q;
  logic             tmo_expired;

  always_ff @(posedge fx2_clk) begin
    if (reset) begin
      tmo_q <= TMO_W'(TIMEOUT_CYCLES - 1);
    end else if (accept) begin
      tmo_q <= TMO_W'(TIMEOUT_CYCLES - 1);
    end else if (is_cmd_state(state_q) && (tmo_q != '0)) begin
      tmo_q <= tmo_q - TMO_W'(1);
    end
  end

  assign tmo_expired = is_cmd_state(state_q) && !bus.cmd_wr && (tmo_q == '0);
`else
  // Without the timeout the parser waits forever, so the limit is not used.
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge fx2_clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_pulse = 1'b0;
    rd_pulse = 1'b0;
    buf_load = 1'b0;
    buf_data = '0;
    buf_len  = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_wr) begin
          if ((bus.cmd == OP_READ) || (bus.cmd == OP_WRITE)) begin
            state_d = ST_ADDR;
          end else begin
            state_d     = ST_REPLY;
            buf_load    = 1'b1;
            buf_len     = REPLY_LEN_W'(1);
            buf_data[0] = (bus.cmd == OP_PING) ? RPL_PING : RPL_ERR;
          end
        end
      end
      ST_ADDR: begin
        if (bus.cmd_wr) begin
          state_d = is_write_q ? ST_DATA0 : ST_EXEC;
        end
      end
      ST_DATA0: if (bus.cmd_wr) state_d = ST_DATA1;
      ST_DATA1: if (bus.cmd_wr) state_d = ST_DATA2;
      ST_DATA2: if (bus.cmd_wr) state_d = ST_DATA3;
      ST_DATA3: if (bus.cmd_wr) state_d = ST_EXEC;
      ST_EXEC: begin
        if (is_write_q) begin
          wr_pulse    = 1'b1;
          state_d     = ST_REPLY;
          buf_load    = 1'b1;
          buf_len     = REPLY_LEN_W'(2);
          buf_data[0] = OP_WRITE;
          buf_data[1] = 8'(addr_q);
        end else begin
          rd_pulse = 1'b1;
          state_d  = ST_RDWAIT;
        end
      end
      ST_RDWAIT: begin
        state_d     = ST_REPLY;
        buf_load    = 1'b1;
        buf_len     = REPLY_LEN_W'(REPLY_MAX);
        buf_data[0] = OP_READ;
        buf_data[1] = 8'(addr_q);
        buf_data[2] = bus.reg_rdata[7:0];
        buf_data[3] = bus.reg_rdata[15:8];
        buf_data[4] = bus.reg_rdata[23:16];
        buf_data[5] = bus.reg_rdata[31:24];
      end
      ST_REPLY: begin
        if (bus.reply_ack && reply_end_w) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef REPLY_TIMEOUT_EN
    if (tmo_expired) begin
      state_d = ST_IDLE;
    end
`endif
  end

  always_ff @(posedge fx2_clk) begin
    if (reset) begin
      is_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      drop_q     <= '0;
    end else if (bus.cmd_wr) begin
      case (state_q)
        ST_IDLE:  is_write_q     <= (bus.cmd == OP_WRITE);
        ST_ADDR:  addr_q         <= ADDR_W'(bus.cmd);
        ST_DATA0: wdata_q[7:0]   <= bus.cmd;
        ST_DATA1: wdata_q[15:8]  <= bus.cmd;
        ST_DATA2: wdata_q[23:16] <= bus.cmd;
        ST_DATA3: wdata_q[31:24] <= bus.cmd;
        default: begin
          if (drop_q != 8'hFF) begin
            drop_q <= drop_q + 8'd1;
          end
        end
      endcase
    end
  end

  reply_buf u_reply_buf (
    .fx2_clk   (fx2_clk),
    .reset     (reset),
    .load      (buf_load),
    .load_data (buf_data),
    .load_len  (buf_len),
    .ack       (bus.reply_ack),
    .reply     (bus.reply),
    .reply_rdy (bus.reply_rdy),
    .reply_end (reply_end_w)
  );

  assign bus.reply_end   = reply_end_w;
  assign bus.reg_addr    = addr_q;
  assign bus.reg_wdata   = wdata_q;
  assign bus.reg_wr      = wr_pulse;
  assign bus.reg_rd      = rd_pulse;
  assign bus.cmd_dropped = drop_q;

endmodule

// File: tb/tb_cmd_responder.sv
// Randomised self-checking bench for cmd_responder with a packet-level reference model.
module tb_cmd_responder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cmd_responder_if #(.ADDR_W(8)) bus ();

  cmd_responder #(.TIMEOUT_CYCLES(16), .ADDR_W(8)) dut (
    .fx2_clk (clk),
    .reset   (reset),
    .bus     (bus.slave)
  );

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] mem [256];
  logic [31:0] rdata_q;
  int          wr_count = 0;
  int          rd_count = 0;
  int          overlap_count = 0;
  logic [7:0]  last_waddr;
  logic [31:0] last_wdata;

  logic [7:0]  cmd_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic        got_end_q[$];
  int          stable_err;
  int          exp_drop;
  int          exp_wr;
  int          exp_rd;
  logic [31:0] exp_wdata;

  // Register-block stand-in: read data valid only in the cycle after reg_rd.
  assign bus.reg_rdata = rdata_q;
  always @(posedge clk) begin
    rdata_q <= bus.reg_rd ? mem[bus.reg_addr] : $urandom;
    if (bus.reg_wr) begin
      wr_count   <= wr_count + 1;
      last_waddr <= bus.reg_addr;
      last_wdata <= bus.reg_wdata;
    end
    if (bus.reg_rd) rd_count <= rd_count + 1;
    if (bus.reg_wr && bus.reg_rd) overlap_count <= overlap_count + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.cmd    = b;
    bus.cmd_wr = 1'b1;
    tick();
    bus.cmd_wr = 1'b0;
    bus.cmd    = 8'($urandom);
  endtask

  // Sends cmd_q with random gaps; stray acks in the gaps must be ignored.
  task automatic send_cmd();
    foreach (cmd_q[i]) begin
      repeat ($urandom_range(0, 2)) begin
        bus.reply_ack = 1'($urandom_range(0, 1));
        tick();
        bus.reply_ack = 1'b0;
      end
      send_byte(cmd_q[i]);
    end
  endtask

  // Reference model: expected reply packet and register side effects of cmd_q.
  function automatic void model_reply();
    logic [7:0]  a;
    logic [31:0] d;
    exp_q.delete();
    exp_wr = 0;
    exp_rd = 0;
    case (cmd_q[0])
      8'h01: begin
        a = cmd_q[1];
        d = mem[a];
        exp_q.push_back(8'h01); exp_q.push_back(a);
        for (int k = 0; k < 4; k++) exp_q.push_back(d[k*8 +: 8]);
        exp_rd = 1;
      end
      8'h02: begin
        a = cmd_q[1];
        d = {cmd_q[5], cmd_q[4], cmd_q[3], cmd_q[2]};
        mem[a] = d;
        exp_wdata = d;
        exp_q.push_back(8'h02); exp_q.push_back(a);
        exp_wr = 1;
      end
      8'h03:   exp_q.push_back(8'hA5);
      default: exp_q.push_back(8'hEE);
    endcase
  endfunction

  task automatic collect_reply(input int max_gap, output bit timed_out);
    int guard;
    got_q.delete();
    got_end_q.delete();
    stable_err = 0;
    timed_out  = 1'b0;
    guard = 0;
    while (!bus.reply_rdy && guard < 20) begin
      tick();
      guard++;
    end
    if (!bus.reply_rdy) begin
      timed_out = 1'b1;
      return;
    end
    guard = 0;
    while (bus.reply_rdy && guard < 16) begin
      got_q.push_back(bus.reply);
      got_end_q.push_back(bus.reply_end);
      repeat ($urandom_range(0, max_gap)) begin
        tick();
        if (bus.reply !== got_q[$] || bus.reply_rdy !== 1'b1) stable_err++;
      end
      bus.reply_ack = 1'b1;
      tick();
      bus.reply_ack = 1'b0;
      guard++;
    end
  endtask

  function automatic logic [63:0] pack_bytes(input bit use_got);
    logic [63:0] v = '0;
    if (use_got) begin
      foreach (got_q[i]) if (i < 7) v[i*8 +: 8] = got_q[i];
      v[63:56] = 8'(got_q.size());
    end else begin
      foreach (exp_q[i]) if (i < 7) v[i*8 +: 8] = exp_q[i];
      v[63:56] = 8'(exp_q.size());
    end
    return v;
  endfunction

  function automatic logic [15:0] end_mask(input bit use_got);
    logic [15:0] m = '0;
    if (use_got) begin
      foreach (got_end_q[i]) if (i < 16) m[i] = got_end_q[i];
    end else if (exp_q.size() > 0) begin
      m[exp_q.size() - 1] = 1'b1;
    end
    return m;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    tests_run++;
    if (bus.reply_rdy !== 1'b0) begin tests_failed++; $display("FAIL rst_reply_rdy: got %0b want 0", bus.reply_rdy); end
    tests_run++;
    if (bus.reply_end !== 1'b0) begin tests_failed++; $display("FAIL rst_reply_end: got %0b want 0", bus.reply_end); end
    tests_run++;
    if (bus.reply !== 8'h00) begin tests_failed++; $display("FAIL rst_reply: got %h want 00", bus.reply); end
    tests_run++;
    if (bus.reg_wr !== 1'b0 || bus.reg_rd !== 1'b0) begin tests_failed++; $display("FAIL rst_strobes: got wr=%0b rd=%0b want 0 0", bus.reg_wr, bus.reg_rd); end
    tests_run++;
    if (bus.reg_addr !== 8'h00) begin tests_failed++; $display("FAIL rst_reg_addr: got %h want 00", bus.reg_addr); end
    tests_run++;
    if (bus.reg_wdata !== 32'h0) begin tests_failed++; $display("FAIL rst_reg_wdata: got %h want 0", bus.reg_wdata); end
    tests_run++;
    if (bus.cmd_dropped !== 8'h00) begin tests_failed++; $display("FAIL rst_cmd_dropped: got %0d want 0", bus.cmd_dropped); end
    reset = 1'b0;
    exp_drop = 0;
    tick();
  endtask

  // Four directed commands followed by randomised READ/WRITE/PING/unknown traffic.
  task automatic test_commands();
    bit          to;
    int          wc, rc, kind;
    logic [7:0]  a;
    mem[8'h20] = 32'hDEADBEEF;
    for (int k = 0; k < 34; k++) begin
      cmd_q.delete();
      if (k < 4) kind = k;
      else kind = $urandom_range(0, 3);
      a = (k < 4) ? ((k == 0) ? 8'h10 : 8'h20) : 8'($urandom_range(0, 15));
      case (kind)
        0: begin
          cmd_q.push_back(8'h02); cmd_q.push_back(a);
          if (k == 0) begin
            cmd_q.push_back(8'h78); cmd_q.push_back(8'h56); cmd_q.push_back(8'h34); cmd_q.push_back(8'h12);
          end else begin
            repeat (4) cmd_q.push_back(8'($urandom));
          end
        end
        1: begin cmd_q.push_back(8'h01); cmd_q.push_back(a); end
        2: cmd_q.push_back(8'h03);
        default: cmd_q.push_back((k == 3) ? 8'h7F : 8'($urandom_range(4, 255)));
      endcase
      model_reply();
      wc = wr_count;
      rc = rd_count;
      send_cmd();
      collect_reply(3, to);
      tests_run++;
      if (to !== 1'b0) begin tests_failed++; $display("FAIL cmd%0d_timeout: no reply_rdy, want reply", k); end
      tests_run++;
      if (pack_bytes(1) !== pack_bytes(0)) begin tests_failed++; $display("FAIL cmd%0d_bytes: got %h want %h", k, pack_bytes(1), pack_bytes(0)); end
      tests_run++;
      if (end_mask(1) !== end_mask(0)) begin tests_failed++; $display("FAIL cmd%0d_reply_end: got %b want %b", k, end_mask(1), end_mask(0)); end
      tests_run++;
      if (stable_err !== 0) begin tests_failed++; $display("FAIL cmd%0d_stable: got %0d changes want 0", k, stable_err); end
      tests_run++;
      if ((wr_count - wc) !== exp_wr || (rd_count - rc) !== exp_rd) begin
        tests_failed++;
        $display("FAIL cmd%0d_strobes: got wr=%0d rd=%0d want wr=%0d rd=%0d", k, wr_count - wc, rd_count - rc, exp_wr, exp_rd);
      end
      if (exp_wr == 1) begin
        tests_run++;
        if (last_waddr !== cmd_q[1] || last_wdata !== exp_wdata) begin
          tests_failed++;
          $display("FAIL cmd%0d_write: got addr=%h data=%h want addr=%h data=%h", k, last_waddr, last_wdata, cmd_q[1], exp_wdata);
        end
      end
    end
    tests_run++;
    if (last_wdata !== 32'h12345678 && wr_count == 0) begin tests_failed++; $display("FAIL write_seen: got none want at least one"); end
  endtask

  task automatic test_final_ack_overlap();
    int guard = 0;
    cmd_q.delete();
    cmd_q.push_back(8'h03);
    send_cmd();
    while (!bus.reply_rdy && guard < 20) begin tick(); guard++; end
    bus.reply_ack = 1'b1;
    bus.cmd_wr    = 1'b1;
    bus.cmd       = 8'h03;
    tick();
    bus.reply_ack = 1'b0;
    bus.cmd_wr    = 1'b0;
    exp_drop++;
    tests_run++;
    if (bus.reply_rdy !== 1'b0) begin tests_failed++; $display("FAIL overlap_rdy: got %0b want 0", bus.reply_rdy); end
    tests_run++;
    if (bus.cmd_dropped !== 8'(exp_drop)) begin tests_failed++; $display("FAIL overlap_dropped: got %0d want %0d", bus.cmd_dropped, exp_drop); end
    repeat (4) tick();
    tests_run++;
    if (bus.reply_rdy !== 1'b0) begin tests_failed++; $display("FAIL overlap_parsed: got reply_rdy=%0b want 0", bus.reply_rdy); end
  endtask

  // Bytes streamed into EXEC, RDWAIT and the first REPLY cycle are all dropped.
  task automatic test_back_to_back();
    bit to;
    cmd_q.delete();
    cmd_q.push_back(8'h01);
    cmd_q.push_back(8'($urandom_range(0, 15)));
    model_reply();
    send_cmd();
    repeat (3) begin
      bus.cmd_wr = 1'b1;
      bus.cmd    = 8'($urandom);
      tick();
    end
    bus.cmd_wr = 1'b0;
    exp_drop += 3;
    tests_run++;
    if (bus.cmd_dropped !== 8'(exp_drop)) begin tests_failed++; $display("FAIL b2b_dropped: got %0d want %0d", bus.cmd_dropped, exp_drop); end
    collect_reply(1, to);
    tests_run++;
    if (to !== 1'b0 || pack_bytes(1) !== pack_bytes(0)) begin tests_failed++; $display("FAIL b2b_bytes: got %h want %h", pack_bytes(1), pack_bytes(0)); end
  endtask

  task automatic test_dropped();
    bit to;
    int guard = 0;
    cmd_q.delete();
    cmd_q.push_back(8'h01);
    cmd_q.push_back(8'h20);
    model_reply();
    send_cmd();
    while (!bus.reply_rdy && guard < 20) begin tick(); guard++; end
    for (int i = 0; i < 300; i++) begin
      bus.cmd_wr = 1'b1;
      bus.cmd    = 8'($urandom);
      tick();
      exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
      if (i == 19) begin
        tests_run++;
        if (bus.cmd_dropped !== 8'(exp_drop)) begin tests_failed++; $display("FAIL drop_mid: got %0d want %0d", bus.cmd_dropped, exp_drop); end
      end
    end
    bus.cmd_wr = 1'b0;
    tests_run++;
    if (bus.cmd_dropped !== 8'd255) begin tests_failed++; $display("FAIL drop_saturate: got %0d want 255", bus.cmd_dropped); end
    tests_run++;
    if (bus.reply !== exp_q[0] || bus.reply_rdy !== 1'b1) begin tests_failed++; $display("FAIL drop_reply_hold: got %h rdy=%0b want %h rdy=1", bus.reply, bus.reply_rdy, exp_q[0]); end
    collect_reply(2, to);
    tests_run++;
    if (to !== 1'b0 || pack_bytes(1) !== pack_bytes(0)) begin tests_failed++; $display("FAIL drop_bytes: got %h want %h", pack_bytes(1), pack_bytes(0)); end
  endtask

  task automatic test_reset_mid();
    bit to;
    int wc;
    int guard = 0;
    cmd_q.delete();
    cmd_q.push_back(8'h01);
    cmd_q.push_back(8'h07);
    model_reply();
    send_cmd();
    while (!bus.reply_rdy && guard < 20) begin tick(); guard++; end
    bus.reply_ack = 1'b1;
    repeat (3) tick();
    bus.reply_ack = 1'b0;
    tests_run++;
    if (bus.reply !== exp_q[3]) begin tests_failed++; $display("FAIL rmid_byte3: got %h want %h", bus.reply, exp_q[3]); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_drop = 0;
    tests_run++;
    if (bus.reply_rdy !== 1'b0 || bus.reply_end !== 1'b0) begin tests_failed++; $display("FAIL rmid_rdy: got rdy=%0b end=%0b want 0 0", bus.reply_rdy, bus.reply_end); end
    tests_run++;
    if (bus.cmd_dropped !== 8'(exp_drop)) begin tests_failed++; $display("FAIL rmid_dropped: got %0d want %0d", bus.cmd_dropped, exp_drop); end
    wc = wr_count;
    send_byte(8'h02);
    send_byte(8'h10);
    send_byte(8'h11);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cmd_q.delete();
    cmd_q.push_back(8'h03);
    model_reply();
    send_cmd();
    collect_reply(2, to);
    tests_run++;
    if (to !== 1'b0 || pack_bytes(1) !== pack_bytes(0)) begin tests_failed++; $display("FAIL rmid_ping: got %h want %h", pack_bytes(1), pack_bytes(0)); end
    tests_run++;
    if (wr_count !== wc) begin tests_failed++; $display("FAIL rmid_no_write: got %0d writes want 0", wr_count - wc); end
  endtask

  task automatic test_timeout();
    bit to;
    int wc;
    wc = wr_count;
`ifdef REPLY_TIMEOUT_EN
    send_byte(8'h02);
    send_byte(8'h10);
    repeat (16) tick();
    cmd_q.delete();
    cmd_q.push_back(8'h03);
    model_reply();
    send_byte(8'h03);
    collect_reply(1, to);
    tests_run++;
    if (to !== 1'b0 || pack_bytes(1) !== pack_bytes(0)) begin tests_failed++; $display("FAIL tmo_ping: got %h want %h", pack_bytes(1), pack_bytes(0)); end
    tests_run++;
    if (wr_count !== wc) begin tests_failed++; $display("FAIL tmo_no_write: got %0d writes want 0", wr_count - wc); end
`else
    cmd_q.delete();
    cmd_q.push_back(8'h02); cmd_q.push_back(8'h10);
    repeat (4) cmd_q.push_back(8'($urandom));
    model_reply();
    send_byte(cmd_q[0]);
    send_byte(cmd_q[1]);
    repeat (40) tick();
    tests_run++;
    if (bus.reply_rdy !== 1'b0 || wr_count !== wc) begin tests_failed++; $display("FAIL wait_idle: got rdy=%0b writes=%0d want 0 0", bus.reply_rdy, wr_count - wc); end
    for (int i = 2; i < 6; i++) send_byte(cmd_q[i]);
    collect_reply(1, to);
    tests_run++;
    if (to !== 1'b0 || pack_bytes(1) !== pack_bytes(0)) begin tests_failed++; $display("FAIL wait_bytes: got %h want %h", pack_bytes(1), pack_bytes(0)); end
    tests_run++;
    if (wr_count - wc !== 1 || last_wdata !== exp_wdata) begin tests_failed++; $display("FAIL wait_write: got n=%0d data=%h want n=1 data=%h", wr_count - wc, last_wdata, exp_wdata); end
`endif
  endtask

  task automatic test_strobe_exclusive();
    tests_run++;
    if (overlap_count !== 0) begin tests_failed++; $display("FAIL strobe_overlap: got %0d cycles want 0", overlap_count); end
  endtask

  initial begin
    bus.cmd_wr    = 1'b0;
    bus.cmd       = 8'h00;
    bus.reply_ack = 1'b0;
    reset         = 1'b1;
    exp_drop      = 0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    test_reset();
    test_commands();
    test_final_ack_overlap();
    test_back_to_back();
    test_dropped();
    test_reset_mid();
    test_timeout();
    test_strobe_exclusive();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
